// File: rtl/axis_eth_pkg.sv
// Shared definitions for the FCS-check arbiter slice: byte-stream width,
// arbiter state encoding and a saturating increment helper.
package axis_eth_pkg;

  localparam int unsigned AXIS_DATA_W = 8;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACTIVE = 1'b1
  } arb_state_t;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/axis_eth_id_fifo.sv
// In-order FIFO of source-port IDs for frames inside the shared checker.
// DEPTH must be a power of two >= 2; push on full and pop on empty are ignored.
module axis_eth_id_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_eth_fcs_check_arb.sv
// Frame-granular round-robin arbiter sharing one FCS checker between PORTS
// ingress streams; output frames are tagged with their source port.
// Define FCS_ARB_STATS_EN to add per-port saturating good/bad frame counters.
module axis_eth_fcs_check_arb
  import axis_eth_pkg::*;
#(
  parameter int unsigned PORTS      = 4,
  parameter int unsigned ID_WIDTH   = $clog2(PORTS),
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PORTS*AXIS_DATA_W-1:0]   s_axis_tdata,
  input  logic [PORTS-1:0]               s_axis_tvalid,
  output logic [PORTS-1:0]               s_axis_tready,
  input  logic [PORTS-1:0]               s_axis_tlast,
  input  logic [PORTS-1:0]               s_axis_tuser,
  output logic [AXIS_DATA_W-1:0]         chk_tdata,
  output logic                           chk_tvalid,
  output logic                           chk_tlast,
  output logic                           chk_tuser,
  input  logic                           chk_tready,
  input  logic [AXIS_DATA_W-1:0]         chk_m_tdata,
  input  logic                           chk_m_tvalid,
  input  logic                           chk_m_tlast,
  input  logic                           chk_m_tuser,
  output logic                           chk_m_tready,
  output logic [AXIS_DATA_W-1:0]         m_axis_tdata,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  output logic [ID_WIDTH-1:0]            m_axis_tid,
  input  logic                           m_axis_tready,
`ifdef FCS_ARB_STATS_EN
  input  logic                           stat_clr,
  output logic [PORTS*CNT_WIDTH-1:0]     stat_good,
  output logic [PORTS*CNT_WIDTH-1:0]     stat_bad,
`endif
  output logic                           busy,
  output logic                           err_underflow
);

  arb_state_t                   state_q, state_d;
  logic [ID_WIDTH-1:0]          grant_q, grant_d;
  logic [ID_WIDTH-1:0]          rr_q, rr_d;
  logic [ID_WIDTH-1:0]          win;
  logic                         win_found;
  logic                         fifo_push, fifo_pop;
  logic [ID_WIDTH-1:0]          fifo_head;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         fifo_full, fifo_empty;

  // First requesting port at or after rr_q, wrapping modulo PORTS.
  always_comb begin
    int unsigned         idx;
    logic [ID_WIDTH-1:0] idx_id;
    win       = '0;
    win_found = 1'b0;
    idx       = 0;
    idx_id    = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= PORTS) idx = idx - PORTS;
      idx_id = idx[ID_WIDTH-1:0];
      if (!win_found && s_axis_tvalid[idx_id]) begin
        win       = idx_id;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    fifo_push     = 1'b0;
    s_axis_tready = '0;
    chk_tdata     = '0;
    chk_tvalid    = 1'b0;
    chk_tlast     = 1'b0;
    chk_tuser     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (win_found && !fifo_full) begin
          grant_d = win;
          state_d = ARB_ACTIVE;
        end
      end
      ARB_ACTIVE: begin
        chk_tdata              = s_axis_tdata[32'(grant_q)*AXIS_DATA_W +: AXIS_DATA_W];
        chk_tvalid             = s_axis_tvalid[grant_q];
        chk_tlast              = s_axis_tlast[grant_q];
        chk_tuser              = s_axis_tuser[grant_q];
        s_axis_tready[grant_q] = chk_tready;
        if (s_axis_tvalid[grant_q] && chk_tready && s_axis_tlast[grant_q]) begin
          fifo_push = 1'b1;
          state_d   = ARB_IDLE;
          rr_d      = (grant_q == ID_WIDTH'(PORTS-1)) ? '0 : grant_q + ID_WIDTH'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  axis_eth_id_fifo #(
    .WIDTH (ID_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (grant_q),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_axis_tdata  = chk_m_tdata;
  assign m_axis_tvalid = chk_m_tvalid;
  assign m_axis_tlast  = chk_m_tlast;
  assign m_axis_tuser  = chk_m_tuser;
  assign chk_m_tready  = m_axis_tready;
  assign m_axis_tid    = fifo_empty ? '0 : fifo_head;
  assign fifo_pop      = m_axis_tvalid & m_axis_tready & m_axis_tlast & ~fifo_empty;
  assign busy          = (state_q == ARB_ACTIVE) | (fifo_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_underflow <= 1'b0;
    else if (m_axis_tvalid && m_axis_tready && fifo_empty)
      err_underflow <= 1'b1;
  end

`ifdef FCS_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] good_q [PORTS];
  logic [CNT_WIDTH-1:0] bad_q  [PORTS];

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < PORTS; p++) begin
        good_q[p] <= '0;
        bad_q[p]  <= '0;
      end
    end else if (stat_clr) begin
      for (int unsigned p = 0; p < PORTS; p++) begin
        good_q[p] <= '0;
        bad_q[p]  <= '0;
      end
    end else if (fifo_pop) begin
      if (m_axis_tuser)
        bad_q[fifo_head]  <= CNT_WIDTH'(sat_inc(32'(bad_q[fifo_head]), CNT_WIDTH));
      else
        good_q[fifo_head] <= CNT_WIDTH'(sat_inc(32'(good_q[fifo_head]), CNT_WIDTH));
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_stat
    assign stat_good[p*CNT_WIDTH +: CNT_WIDTH] = good_q[p];
    assign stat_bad[p*CNT_WIDTH +: CNT_WIDTH]  = bad_q[p];
  end
`endif

endmodule
